nes_pll_reset_seq: RTL and testbench



---
 rtl/nes_pll_seq_pkg.sv | 23 ++
 rtl/nes_sync_2ff.sv | 25 ++
 rtl/nes_pll_reset_seq.sv | 141 ++++++++++++++
 tb/tb_nes_pll_reset_seq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_pll_seq_pkg.sv
// Shared types and helpers for the NES PLL / core reset sequencer.
package nes_pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } seq_state_e;

    localparam int RELOCK_W = 8;

    // Width of a counter that must reach the largest of three cycle budgets.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/nes_sync_2ff.sv
// Single-bit two-flop synchronizer, clears to 0 on async reset.
module nes_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give metastability a full cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/nes_pll_reset_seq.sv
// PLL reset / region select sequencer: holds the core in reset until the
// PLL has shown a stable lock, re-sequences on lock loss or region change,
// and gives up with a fault after repeated lock timeouts.
module nes_pll_reset_seq
    import nes_pll_seq_pkg::*;
#(
    parameter int RST_CYCLES         = 16,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT       = 1048576,
    parameter int MAX_RETRY          = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pal_req,
    input  logic                pll_locked,
    output logic                pll_rst,
    output logic                pll_pal_sel,
    output logic                core_reset_n,
    output logic                ready,
    output logic                fault,
    output logic [RELOCK_W-1:0] relock_count
);

    localparam int CNT_W = cnt_width(LOCK_TIMEOUT, LOCK_STABLE_CYCLES, RST_CYCLES);
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    logic locked_s;
    logic pal_s;

    nes_sync_2ff u_sync_lock (.clk(clk), .rst_n(reset_n), .d(pll_locked), .q(locked_s));
    nes_sync_2ff u_sync_pal  (.clk(clk), .rst_n(reset_n), .d(pal_req),    .q(pal_s));

    seq_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RTY_W-1:0]    retry_q, retry_d;
    logic                pll_rst_q, pll_rst_d;
    logic                pal_sel_q, pal_sel_d;
    logic                core_rst_n_q, core_rst_n_d;
    logic                ready_q, ready_d;
    logic                fault_q, fault_d;
    logic [RELOCK_W-1:0] relock_q, relock_d;

    // Next-state, counters and registered-output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        retry_d   = retry_q;
        pal_sel_d = pal_sel_q;
        relock_d  = relock_q;

        case (state_q)
            PLL_RST: begin
                // Region select only moves while the PLL is held in reset.
                pal_sel_d = pal_s;
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // Lock seen on the timeout cycle still counts as a lock.
                if (locked_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TO_LAST) begin
                    retry_d = retry_q + RTY_W'(1);
                    state_d = (retry_d == RTY_MAX) ? FAULT : PLL_RST;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STB_LAST) begin
                    state_d = RUN;
                    retry_d = '0;
                end
            end
            RUN: begin
                cnt_d = '0;
                // Lock loss outranks a region change and is the only one counted.
                if (!locked_s) begin
                    state_d = PLL_RST;
                    if (relock_q != '1) relock_d = relock_q + RELOCK_W'(1);
                end else if (pal_s != pal_sel_q) begin
                    state_d = PLL_RST;
                end
            end
            FAULT: begin
                cnt_d = '0;
                // A region change is the only way out short of a hard reset.
                if (pal_s != pal_sel_q) begin
                    state_d = PLL_RST;
                    retry_d = '0;
                end
            end
            default: state_d = PLL_RST;
        endcase

        if (state_d != state_q) cnt_d = '0;

        pll_rst_d    = (state_d == PLL_RST);
        fault_d      = (state_d == FAULT);
        // Core release waits one full cycle in RUN but drops on the exit edge.
        core_rst_n_d = (state_q == RUN) && (state_d == RUN);
        ready_d      = core_rst_n_d;
    end

    // State, counters and output registers; reset forces the safe outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= PLL_RST;
            cnt_q        <= '0;
            retry_q      <= '0;
            pll_rst_q    <= 1'b1;
            pal_sel_q    <= 1'b0;
            core_rst_n_q <= 1'b0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
            relock_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            pll_rst_q    <= pll_rst_d;
            pal_sel_q    <= pal_sel_d;
            core_rst_n_q <= core_rst_n_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
            relock_q     <= relock_d;
        end
    end

    assign pll_rst      = pll_rst_q;
    assign pll_pal_sel  = pal_sel_q;
    assign core_reset_n = core_rst_n_q;
    assign ready        = ready_q;
    assign fault        = fault_q;
    assign relock_count = relock_q;

endmodule

// File: tb/tb_nes_pll_reset_seq.sv
// Scoreboard bench for nes_pll_reset_seq: stimulus pushes cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_nes_pll_reset_seq;

    localparam int SIG_RST    = 0;
    localparam int SIG_SEL    = 1;
    localparam int SIG_CORE   = 2;
    localparam int SIG_READY  = 3;
    localparam int SIG_FAULT  = 4;
    localparam int SIG_RELOCK = 5;

    typedef struct {
        int         cyc;
        int         sig;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   base   = 0;
    int   errors = 0;
    int   checks = 0;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pal_req;
    logic       pll_locked;
    logic       pll_rst;
    logic       pll_pal_sel;
    logic       core_reset_n;
    logic       ready;
    logic       fault;
    logic [7:0] relock_count;

    nes_pll_reset_seq #(
        .RST_CYCLES(4), .LOCK_STABLE_CYCLES(8), .LOCK_TIMEOUT(32), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pal_req(pal_req), .pll_locked(pll_locked),
        .pll_rst(pll_rst), .pll_pal_sel(pll_pal_sel), .core_reset_n(core_reset_n),
        .ready(ready), .fault(fault), .relock_count(relock_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] dut_val(input int sig);
        case (sig)
            SIG_RST:   return {7'd0, pll_rst};
            SIG_SEL:   return {7'd0, pll_pal_sel};
            SIG_CORE:  return {7'd0, core_reset_n};
            SIG_READY: return {7'd0, ready};
            SIG_FAULT: return {7'd0, fault};
            default:   return relock_count;
        endcase
    endfunction

    function automatic string sig_name(input int sig);
        case (sig)
            SIG_RST:   return "pll_rst";
            SIG_SEL:   return "pll_pal_sel";
            SIG_CORE:  return "core_reset_n";
            SIG_READY: return "ready";
            SIG_FAULT: return "fault";
            default:   return "relock_count";
        endcase
    endfunction

    task automatic expect_at(input int rel, input int sig, input logic [7:0] val);
        exp_t e;
        e.cyc = base + rel;
        e.sig = sig;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic expect_reset_state(input int rel);
        expect_at(rel, SIG_RST, 8'd1);
        expect_at(rel, SIG_SEL, 8'd0);
        expect_at(rel, SIG_CORE, 8'd0);
        expect_at(rel, SIG_READY, 8'd0);
        expect_at(rel, SIG_FAULT, 8'd0);
        expect_at(rel, SIG_RELOCK, 8'd0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation due at this cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                checks++;
                if (e.cyc != cyc || dut_val(e.sig) !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d due=%0d got=%0d expected=%0d",
                             sig_name(e.sig), cyc, e.cyc, dut_val(e.sig), e.val);
                end
            end
        end
    end

    initial begin : stim
        bit ok;
        reset_n    = 1'b0;
        pll_locked = 1'b1;
        pal_req    = 1'b0;
        expect_reset_state(2);

        // Power-up with lock already present.
        tick(3);
        reset_n = 1'b1;
        base = cyc;
        for (int k = 0; k < 4; k++) expect_at(k, SIG_RST, 8'd1);
        expect_at(4, SIG_RST, 8'd0);
        expect_at(13, SIG_CORE, 8'd0);
        expect_at(13, SIG_READY, 8'd0);
        expect_at(14, SIG_CORE, 8'd1);
        expect_at(14, SIG_READY, 8'd1);
        expect_at(14, SIG_RELOCK, 8'd0);
        expect_at(14, SIG_FAULT, 8'd0);
        expect_at(14, SIG_SEL, 8'd0);
        tick(15);

        // One-cycle lock loss in RUN.
        base = cyc;
        pll_locked = 1'b0;
        expect_at(2, SIG_CORE, 8'd1);
        expect_at(2, SIG_RST, 8'd0);
        expect_at(3, SIG_CORE, 8'd0);
        expect_at(3, SIG_READY, 8'd0);
        expect_at(3, SIG_RST, 8'd1);
        expect_at(3, SIG_RELOCK, 8'd1);
        expect_at(6, SIG_RST, 8'd1);
        expect_at(7, SIG_RST, 8'd0);
        expect_at(16, SIG_CORE, 8'd0);
        expect_at(17, SIG_CORE, 8'd1);
        expect_at(17, SIG_RELOCK, 8'd1);
        tick(1);
        pll_locked = 1'b1;
        tick(17);

        // Region change NTSC -> PAL in RUN.
        base = cyc;
        pal_req = 1'b1;
        expect_at(2, SIG_CORE, 8'd1);
        expect_at(2, SIG_SEL, 8'd0);
        expect_at(3, SIG_RST, 8'd1);
        expect_at(3, SIG_CORE, 8'd0);
        expect_at(3, SIG_SEL, 8'd0);
        expect_at(4, SIG_SEL, 8'd1);
        expect_at(7, SIG_RST, 8'd0);
        expect_at(16, SIG_CORE, 8'd0);
        expect_at(17, SIG_CORE, 8'd1);
        expect_at(17, SIG_RELOCK, 8'd1);
        expect_at(17, SIG_SEL, 8'd1);
        tick(18);

        // Async reset while in RUN.
        base = cyc;
        reset_n = 1'b0;
        expect_reset_state(0);
        tick(1);

        // Lock glitch at stable count 5 forces a fresh stable window.
        reset_n = 1'b1;
        base = cyc;
        expect_at(4, SIG_RST, 8'd0);
        expect_at(4, SIG_SEL, 8'd1);
        expect_at(12, SIG_RST, 8'd0);
        expect_at(14, SIG_CORE, 8'd0);
        expect_at(20, SIG_CORE, 8'd0);
        expect_at(21, SIG_CORE, 8'd1);
        expect_at(21, SIG_READY, 8'd1);
        tick(8);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(13);

        // Reset pulse, then async reset while in STABLE.
        base = cyc;
        reset_n = 1'b0;
        expect_reset_state(0);
        tick(1);
        reset_n = 1'b1;
        base = cyc;
        expect_at(7, SIG_RST, 8'd0);
        expect_at(7, SIG_CORE, 8'd0);
        tick(8);
        base = cyc;
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        pal_req    = 1'b0;
        expect_reset_state(0);
        tick(1);

        // No lock ever: two timed-out attempts, then FAULT.
        reset_n = 1'b1;
        base = cyc;
        for (int k = 0; k < 4; k++) expect_at(k, SIG_RST, 8'd1);
        expect_at(4, SIG_RST, 8'd0);
        expect_at(35, SIG_RST, 8'd0);
        expect_at(36, SIG_RST, 8'd1);
        expect_at(39, SIG_RST, 8'd1);
        expect_at(40, SIG_RST, 8'd0);
        expect_at(71, SIG_FAULT, 8'd0);
        expect_at(72, SIG_FAULT, 8'd1);
        expect_at(72, SIG_RST, 8'd0);
        expect_at(72, SIG_CORE, 8'd0);
        expect_at(72, SIG_READY, 8'd0);
        tick(74);

        // Region toggle clears the fault and restarts; lock arrives later.
        base = cyc;
        pal_req = 1'b1;
        expect_at(2, SIG_FAULT, 8'd1);
        expect_at(3, SIG_FAULT, 8'd0);
        expect_at(3, SIG_RST, 8'd1);
        expect_at(4, SIG_SEL, 8'd1);
        tick(5);
        pll_locked = 1'b1;
        expect_at(17, SIG_CORE, 8'd1);
        expect_at(17, SIG_FAULT, 8'd0);

        // 300 lock losses saturate relock_count at 255.
        for (int i = 0; i < 300; i++) begin
            ok = 1'b0;
            for (int w = 0; w < 60; w++) begin
                if (ready === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
                tick(1);
            end
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout loss=%0d got=ready_low expected=ready_high", i);
                break;
            end
            pll_locked = 1'b0;
            tick(1);
            pll_locked = 1'b1;
            tick(3);
        end
        base = cyc;
        expect_at(0, SIG_RELOCK, 8'd255);
        expect_at(0, SIG_READY, 8'd0);

        // Drain the scoreboard with a bound.
        for (int w = 0; w < 50 && exp_q.size() > 0; w++) tick(1);
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s unchecked due=%0d got=none expected=%0d",
                     sig_name(e.sig), e.cyc, e.val);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
